// File: rtl/count_ctrl_if.sv
// Control/status bundle between the sequencing logic and count_ctrl.
// The hold signal exists only when COUNT_CTRL_HOLD_EN is defined.
interface count_ctrl_if #(
  parameter int WIDTH = 4
);
  logic             start;
  logic             stop;
  logic             mode;
  logic [WIDTH-1:0] load_val;
`ifdef COUNT_CTRL_HOLD_EN
  logic             hold;
`endif
  logic             cnt_en;
  logic [WIDTH-1:0] q;
  logic             busy;
  logic             done;

  modport master (
    output
`ifdef COUNT_CTRL_HOLD_EN
           hold,
`endif
           start, stop, mode, load_val,
    input  cnt_en, q, busy, done
  );

  modport slave (
    input
`ifdef COUNT_CTRL_HOLD_EN
           hold,
`endif
           start, stop, mode, load_val,
    output cnt_en, q, busy, done
  );
endinterface

// File: rtl/count_ctrl.sv
// Bounded-run sequencer for the ripple counter: prescaled advance strobes, terminal
// detection, one-shot/periodic runs and a registered done pulse. Optional pause via COUNT_CTRL_HOLD_EN.
module count_ctrl #(
  parameter int WIDTH = 4,
  parameter int DIV   = 1
) (
  input  logic        ck_i,
  input  logic        res_i,
  count_ctrl_if.slave bus
);
  localparam int             PW         = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0]  PRESC_LAST = PW'(DIV - 1);

  typedef enum logic [1:0] {IDLE, RUN, HOLD} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] term_q, term_d;
  logic [PW-1:0]    presc_q, presc_d;
  logic             done_q, done_d;
  logic             tick;
  logic             at_term;

  assign tick    = (state_q == RUN) && (presc_q == PRESC_LAST);
  assign at_term = (q_q == term_q);

  always_ff @(posedge ck_i or negedge res_i) begin
    if (!res_i) begin
      state_q <= IDLE;
      q_q     <= '0;
      term_q  <= '0;
      presc_q <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      q_q     <= q_d;
      term_q  <= term_d;
      presc_q <= presc_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    q_d     = q_q;
    term_d  = term_q;
    presc_d = presc_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          term_d  = bus.load_val;
          q_d     = '0;
          presc_d = '0;
          state_d = RUN;
        end
      end
      RUN, HOLD: begin
        if (bus.stop) begin
          presc_d = '0;
          state_d = IDLE;
        end else if (bus.start) begin
          term_d  = bus.load_val;
          q_d     = '0;
          presc_d = '0;
          state_d = RUN;
        end else if (state_q == RUN) begin
          presc_d = tick ? '0 : presc_q + PW'(1);
          if (tick) begin
            if (!at_term) begin
              q_d = q_q + WIDTH'(1);
            end else begin
              done_d = 1'b1;
              if (bus.mode) q_d = '0;
              else          state_d = IDLE;
            end
          end
`ifdef COUNT_CTRL_HOLD_EN
          // A strobe already issued this cycle is honoured; freezing starts in HOLD.
          if (bus.hold && state_d == RUN) state_d = HOLD;
`endif
        end
`ifdef COUNT_CTRL_HOLD_EN
        else if (!bus.hold) begin
          state_d = RUN;
        end
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.cnt_en = tick;
    bus.busy   = (state_q != IDLE);
    bus.q      = q_q;
    bus.done   = done_q;
  end
endmodule

// File: tb/tb_count_ctrl.sv
// Scoreboard bench for count_ctrl: three instances with DIV=1,2,3; expected done
// events are queued at stimulus time and matched by per-instance monitors.
module tb_count_ctrl;
  localparam int W = 4;
  localparam int N = 3;

  typedef struct {
    int         cyc;
    logic [W-1:0] q;
    logic       busy;
  } exp_t;

  logic ck  = 1'b0;
  logic res = 1'b0;
  int   cyc = 0;
  int   tests = 0;
  int   fails = 0;

  logic         start_s [N];
  logic         stop_s  [N];
  logic         mode_s  [N];
  logic [W-1:0] load_s  [N];
  logic         hold_s  [N];
  logic [W-1:0] q_o     [N];
  logic         done_o  [N];
  logic         busy_o  [N];
  logic         cnt_en_o[N];
  exp_t         exp_q   [N][$];

  always #5 ck = ~ck;
  always @(posedge ck) cyc <= cyc + 1;

  task automatic check(string name, int act, int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, required %0d", name, act, exp);
    end
  endtask

  count_ctrl_if #(.WIDTH(W)) bus[N] ();

  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_dut
      exp_t e;
      assign bus[gi].start    = start_s[gi];
      assign bus[gi].stop     = stop_s[gi];
      assign bus[gi].mode     = mode_s[gi];
      assign bus[gi].load_val = load_s[gi];
`ifdef COUNT_CTRL_HOLD_EN
      assign bus[gi].hold     = hold_s[gi];
`endif
      assign q_o[gi]      = bus[gi].q;
      assign done_o[gi]   = bus[gi].done;
      assign busy_o[gi]   = bus[gi].busy;
      assign cnt_en_o[gi] = bus[gi].cnt_en;

      count_ctrl #(.WIDTH(W), .DIV(gi + 1)) u_dut (
        .ck_i  (ck),
        .res_i (res),
        .bus   (bus[gi])
      );

      always @(negedge ck) begin
        if (done_o[gi]) begin
          if (exp_q[gi].size() == 0) begin
            tests++;
            fails++;
            $display("FAIL done_unexpected[%0d]: got done at cycle %0d, required none", gi, cyc);
          end else begin
            e = exp_q[gi].pop_front();
            $display("[TB] inst%0d done cycle=%0d q=%0d busy=%0b", gi, cyc, q_o[gi], busy_o[gi]);
            check($sformatf("done_cycle[%0d]", gi), cyc, e.cyc);
            check($sformatf("done_q[%0d]", gi), int'(q_o[gi]), int'(e.q));
            check($sformatf("done_busy[%0d]", gi), int'(busy_o[gi]), int'(e.busy));
          end
        end
      end
    end
  endgenerate

  // Called at a negedge; returns at the negedge after the start edge E0.
  task automatic start_run(int i, int ld, logic md, int periods);
    exp_t x;
    int   c0;
    c0 = cyc + 1;
    start_s[i] = 1'b1;
    load_s[i]  = W'(ld);
    mode_s[i]  = md;
    for (int p = 1; p <= periods; p++) begin
      x.cyc  = c0 + p * (ld + 1) * (i + 1);
      x.q    = md ? '0 : W'(ld);
      x.busy = md;
      exp_q[i].push_back(x);
    end
    @(negedge ck);
    start_s[i] = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < N; i++) begin
      start_s[i] = 1'b0; stop_s[i] = 1'b0; mode_s[i] = 1'b0;
      load_s[i] = '0; hold_s[i] = 1'b0;
    end
    @(negedge ck);
    for (int i = 0; i < N; i++) begin
      check($sformatf("rst_q[%0d]", i), int'(q_o[i]), 0);
      check($sformatf("rst_busy[%0d]", i), int'(busy_o[i]), 0);
    end
    check("rst_done", int'(done_o[0]), 0);
    check("rst_cnt_en", int'(cnt_en_o[0]), 0);
    res = 1'b1;
    @(negedge ck);

    // One-shot, DIV=1, load 3
    start_run(0, 3, 1'b0, 1);
    check("os_q0", int'(q_o[0]), 0);
    check("os_busy0", int'(busy_o[0]), 1);
    for (int k = 1; k <= 3; k++) begin
      @(negedge ck);
      check($sformatf("os_q%0d", k), int'(q_o[0]), k);
    end
    @(negedge ck);
    check("os_busy_end", int'(busy_o[0]), 0);
    check("os_q_end", int'(q_o[0]), 3);
    @(negedge ck);
    check("os_done_width", int'(done_o[0]), 0);
    check("os_q_hold", int'(q_o[0]), 3);

    // Periodic, DIV=2, load 1: three periods then stop
    start_run(1, 1, 1'b1, 3);
    for (int k = 0; k < 8; k++) begin
      check($sformatf("per_q_e%0d", k), int'(q_o[1]), (k / 2) % 2);
      check($sformatf("per_cnt_en_e%0d", k), int'(cnt_en_o[1]), k % 2);
      @(negedge ck);
    end
    repeat (5) @(negedge ck);
    stop_s[1] = 1'b1;
    @(negedge ck);
    stop_s[1] = 1'b0;
    check("per_stop_busy", int'(busy_o[1]), 0);
    check("per_stop_cnt_en", int'(cnt_en_o[1]), 0);

    // Stop at q=2, load 5
    start_run(0, 5, 1'b0, 0);
    @(negedge ck);
    @(negedge ck);
    check("stop_pre_q", int'(q_o[0]), 2);
    stop_s[0] = 1'b1;
    @(negedge ck);
    stop_s[0] = 1'b0;
    check("stop_q", int'(q_o[0]), 2);
    check("stop_busy", int'(busy_o[0]), 0);
    repeat (3) @(negedge ck);
    check("stop_q_later", int'(q_o[0]), 2);

    // Stop coincident with terminal tick
    start_run(0, 1, 1'b0, 0);
    @(negedge ck);
    stop_s[0] = 1'b1;
    @(negedge ck);
    stop_s[0] = 1'b0;
    check("stopterm_q", int'(q_o[0]), 1);
    check("stopterm_busy", int'(busy_o[0]), 0);
    repeat (3) @(negedge ck);

    // Start coincident with terminal tick
    start_run(0, 2, 1'b0, 0);
    @(negedge ck);
    @(negedge ck);
    start_run(0, 2, 1'b0, 1);
    check("restart_q", int'(q_o[0]), 0);
    check("restart_busy", int'(busy_o[0]), 1);
    repeat (4) @(negedge ck);
    check("restart_end_busy", int'(busy_o[0]), 0);

    // Boundary terminal counts
    start_run(0, 0, 1'b0, 1);
    @(negedge ck);
    check("ld0_busy", int'(busy_o[0]), 0);
    check("ld0_q", int'(q_o[0]), 0);
    start_run(0, 15, 1'b0, 1);
    repeat (15) @(negedge ck);
    check("ld15_q15", int'(q_o[0]), 15);
    check("ld15_busy", int'(busy_o[0]), 1);
    @(negedge ck);
    check("ld15_end_busy", int'(busy_o[0]), 0);
    repeat (2) @(negedge ck);
    check("ld15_nowrap", int'(q_o[0]), 15);

    // DIV=3, load 3 (with a 5-cycle pause when the hold feature is built)
`ifdef COUNT_CTRL_HOLD_EN
    begin
      exp_t x;
      x.cyc = cyc + 1 + 12 + 5;
      x.q = 3;
      x.busy = 1'b0;
      exp_q[2].push_back(x);
      start_s[2] = 1'b1; load_s[2] = 4'd3; mode_s[2] = 1'b0;
      @(negedge ck);
      start_s[2] = 1'b0;
      repeat (3) @(negedge ck);
      check("hold_pre_q", int'(q_o[2]), 1);
      hold_s[2] = 1'b1;
      for (int j = 0; j < 5; j++) begin
        @(negedge ck);
        check($sformatf("hold_q%0d", j), int'(q_o[2]), 1);
        check($sformatf("hold_cnt_en%0d", j), int'(cnt_en_o[2]), 0);
        check($sformatf("hold_busy%0d", j), int'(busy_o[2]), 1);
      end
      hold_s[2] = 1'b0;
      repeat (12) @(negedge ck);
    end
`else
    start_run(2, 3, 1'b0, 1);
    repeat (3) @(negedge ck);
    check("div3_q1", int'(q_o[2]), 1);
    repeat (10) @(negedge ck);
    check("div3_busy_end", int'(busy_o[2]), 0);
`endif

    // Asynchronous reset mid-run at q=2
    start_run(0, 5, 1'b0, 0);
    @(negedge ck);
    @(negedge ck);
    check("arst_pre_q", int'(q_o[0]), 2);
    #2 res = 1'b0;
    #1;
    check("arst_q", int'(q_o[0]), 0);
    check("arst_busy", int'(busy_o[0]), 0);
    check("arst_done", int'(done_o[0]), 0);
    check("arst_cnt_en", int'(cnt_en_o[0]), 0);
    @(negedge ck);
    res = 1'b1;
    repeat (3) @(negedge ck);
    check("arst_idle_q", int'(q_o[0]), 0);
    check("arst_idle_busy", int'(busy_o[0]), 0);

    for (int i = 0; i < N; i++)
      check($sformatf("done_missing[%0d]", i), exp_q[i].size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
